// File: rtl/sobel_grad_pipe.sv
// Streaming 3x3 Sobel gradient unit: three valid/ready stages, gx/gy -> |gx|,|gy| -> mag/edge/dir.
// Optional quantised direction output is built only when SOBEL_DIR_EN is defined.
module sobel_grad_pipe #(
    parameter int PIX_W    = 8,
    parameter int OUT_W    = 16,
    parameter int MAG_MODE = 0,
    parameter int USER_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [PIX_W-1:0]        p00_i,
    input  logic [PIX_W-1:0]        p01_i,
    input  logic [PIX_W-1:0]        p02_i,
    input  logic [PIX_W-1:0]        p10_i,
    input  logic [PIX_W-1:0]        p11_i,
    input  logic [PIX_W-1:0]        p12_i,
    input  logic [PIX_W-1:0]        p20_i,
    input  logic [PIX_W-1:0]        p21_i,
    input  logic [PIX_W-1:0]        p22_i,
    input  logic [OUT_W-1:0]        thresh_i,
    input  logic [USER_W-1:0]       in_user_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [OUT_W-1:0] gx_o,
    output logic signed [OUT_W-1:0] gy_o,
    output logic [OUT_W-1:0]        mag_o,
    output logic                    edge_o,
    output logic [1:0]              dir_o,
    output logic [USER_W-1:0]       out_user_o
);

    if (OUT_W < PIX_W + 3) begin : g_bad_width
        $error("sobel_grad_pipe: OUT_W must be >= PIX_W+3");
    end

    typedef logic signed [OUT_W-1:0] sgrad_t;
    typedef logic [OUT_W-1:0]        ugrad_t;

    function automatic sgrad_t zext(input logic [PIX_W-1:0] p);
        return sgrad_t'({{(OUT_W-PIX_W){1'b0}}, p});
    endfunction

    // The centre pixel carries no weight in either kernel.
    logic unused_p11;
    assign unused_p11 = ^p11_i;

    logic v1_q, v2_q, v3_q;
    logic ld1, ld2, ld3;

    // Ready ripples combinationally from the output back to the input.
    assign ld3        = !v3_q || out_ready_i;
    assign ld2        = !v2_q || ld3;
    assign ld1        = !v1_q || ld2;
    assign in_ready_o = ld1;

    // ---------------- Stage 1: signed gradients ----------------
    sgrad_t              gx1_d, gy1_d, gx1_q, gy1_q;
    ugrad_t              th1_q;
    logic [USER_W-1:0]   user1_q;

    always_comb begin
        gx1_d = (zext(p02_i) + (zext(p12_i) <<< 1) + zext(p22_i))
              - (zext(p00_i) + (zext(p10_i) <<< 1) + zext(p20_i));
        gy1_d = (zext(p00_i) + (zext(p01_i) <<< 1) + zext(p02_i))
              - (zext(p20_i) + (zext(p21_i) <<< 1) + zext(p22_i));
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so stage order is irrelevant.
    // NOTE: datapath registers are not reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (!rst_n)   v1_q <= 1'b0;
        else if (ld1) v1_q <= in_valid_i;
        if (ld1 && in_valid_i) begin
            gx1_q   <= gx1_d;
            gy1_q   <= gy1_d;
            th1_q   <= thresh_i;
            user1_q <= in_user_i;
        end
    end

    // ---------------- Stage 2: absolute values ----------------
    ugrad_t              ax2_d, ay2_d, ax2_q, ay2_q, th2_q;
    sgrad_t              gx2_q, gy2_q;
    logic [USER_W-1:0]   user2_q;

    always_comb begin
        ax2_d = gx1_q[OUT_W-1] ? ugrad_t'(-gx1_q) : ugrad_t'(gx1_q);
        ay2_d = gy1_q[OUT_W-1] ? ugrad_t'(-gy1_q) : ugrad_t'(gy1_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)   v2_q <= 1'b0;
        else if (ld2) v2_q <= v1_q;
        if (ld2 && v1_q) begin
            ax2_q   <= ax2_d;
            ay2_q   <= ay2_d;
            gx2_q   <= gx1_q;
            gy2_q   <= gy1_q;
            th2_q   <= th1_q;
            user2_q <= user1_q;
        end
    end

    // ---------------- Stage 3: magnitude, edge, direction ----------------
    ugrad_t mx, mn, mag3_d;
    logic   edge3_d;
    logic [1:0] dir3_d;

`ifdef SOBEL_DIR_EN
    logic [OUT_W+2:0] ax_e, ay_e, ax5, ay5, ax2x, ay2x;
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        mx      = (ax2_q >= ay2_q) ? ax2_q : ay2_q;
        mn      = (ax2_q >= ay2_q) ? ay2_q : ax2_q;
        mag3_d  = ax2_q + ay2_q;
        dir3_d  = 2'b00;
        if (MAG_MODE == 1) mag3_d = mx + (mn >> 1);
        edge3_d = mag3_d > th2_q;
`ifdef SOBEL_DIR_EN
        ax_e = {3'b000, ax2_q};
        ay_e = {3'b000, ay2_q};
        ax5  = (ax_e << 2) + ax_e;
        ay5  = (ay_e << 2) + ay_e;
        ax2x = ax_e << 1;
        ay2x = ay_e << 1;
        if (ay5 <= ax2x)                          dir3_d = 2'd0;
        else if (ax5 <= ay2x)                     dir3_d = 2'd2;
        else if (gx2_q[OUT_W-1] == gy2_q[OUT_W-1]) dir3_d = 2'd1;
        else                                      dir3_d = 2'd3;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_q       <= 1'b0;
            gx_o       <= '0;
            gy_o       <= '0;
            mag_o      <= '0;
            edge_o     <= 1'b0;
            dir_o      <= 2'b00;
            out_user_o <= '0;
        end else begin
            if (ld3) v3_q <= v2_q;
            if (ld3 && v2_q) begin
                gx_o       <= gx2_q;
                gy_o       <= gy2_q;
                mag_o      <= mag3_d;
                edge_o     <= edge3_d;
                dir_o      <= dir3_d;
                out_user_o <= user2_q;
            end
        end
    end

    assign out_valid_o = v3_q;

endmodule
